// File: rtl/queen_search_controller.sv
// Control FSM for the 8-queen datapath: row-by-row placement with safety checks,
// column advance and backtracking, then streaming of the solved board rows.
module queen_search_controller #(
  parameter int unsigned BT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            cout,
  input  logic            down_counter_zero,
  input  logic            last_queen_counter_zero,
  input  logic            last_cell,
  input  logic            safe,
  output logic            shift_right,
  output logic            counter_reset,
  output logic            count_up,
  output logic            count_down,
  output logic            count,
  output logic            load_counter,
  output logic            enable_output,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [BT_W-1:0] backtracks
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_PLACE,
    S_LOAD,
    S_COMPARE,
    S_NEXT,
    S_CONFLICT,
    S_ADVANCE,
    S_BACKTRACK,
    S_BACK_SHIFT,
    S_BACK_DEC,
    S_OUT_RST,
    S_OUT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t state;

  // State sequencing and saturating backtrack counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      backtracks <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_INIT;
            backtracks <= '0;
          end
        end
        S_INIT:  state <= S_PLACE;
        S_PLACE: begin
          if (cout)                         state <= S_OUT_RST;
          else if (last_queen_counter_zero) state <= S_NEXT;
          else                              state <= S_LOAD;
        end
        S_LOAD:  state <= S_COMPARE;
        // Stays here while count walks the other-queen row toward row 0
        S_COMPARE: begin
          if (!safe)                  state <= S_CONFLICT;
          else if (down_counter_zero) state <= S_NEXT;
        end
        S_NEXT:       state <= S_PLACE;
        S_CONFLICT:   state <= last_cell ? S_BACKTRACK : S_ADVANCE;
        S_ADVANCE:    state <= S_PLACE;
        S_BACKTRACK:  state <= last_queen_counter_zero ? S_FAIL : S_BACK_SHIFT;
        S_BACK_SHIFT: state <= S_BACK_DEC;
        S_BACK_DEC: begin
          state <= S_CONFLICT;
          if (backtracks != '1) backtracks <= backtracks + BT_W'(1);
        end
        S_OUT_RST: state <= S_OUT;
        S_OUT: begin
          if (cout) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_FAIL:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe decode from the state register; count and the output pair also gate on status
  always_comb begin
    shift_right   = 1'b0;
    counter_reset = 1'b0;
    count_up      = 1'b0;
    count_down    = 1'b0;
    count         = 1'b0;
    load_counter  = 1'b0;
    enable_output = 1'b0;
    done          = 1'b0;
    fail          = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_INIT, S_OUT_RST:        counter_reset = 1'b1;
      S_LOAD:                   load_counter  = 1'b1;
      S_COMPARE:                count         = safe && !down_counter_zero;
      S_NEXT:                   count_up      = 1'b1;
      S_ADVANCE, S_BACK_SHIFT:  shift_right   = 1'b1;
      S_BACK_DEC:               count_down    = 1'b1;
      S_OUT: begin
        enable_output = !cout;
        count_up      = !cout;
      end
      S_DONE:  done = 1'b1;
      S_FAIL:  fail = 1'b1;
      default: ;
    endcase
  end

endmodule
